// File: rtl/tmds_serializer_multi_if.sv
// Word-input handshake bundle for tmds_serializer_multi.
//   i_data  : NCH packed lane words, lane k at [k*WORD_W +: WORD_W]
//   i_valid : i_data carries a word
//   o_ready : serializer can take i_data this cycle
// master = word producer (encoder side), slave = serializer.
interface tmds_serializer_multi_if #(
  parameter int unsigned WORD_W = 10,
  parameter int unsigned NCH    = 3
);
  logic [NCH*WORD_W-1:0] i_data;
  logic                  i_valid;
  logic                  o_ready;

  modport master (output i_data, output i_valid, input  o_ready);
  modport slave  (input  i_data, input  i_valid, output o_ready);
endinterface

// File: rtl/tmds_serializer_multi.sv
// Multi-lane word serializer for TMDS output paths.
// Takes one WORD_W-bit word per lane through a valid/ready handshake into a
// one-entry holding register and emits BITS_PER_CLK bits per lane per clock,
// LSB first. A missing word at a word boundary is replaced by IDLE_WORD and
// flags a sticky underflow (only after the first word has ever been taken).
// Ports:
//   i_clk           serial-side clock (bit clock / BITS_PER_CLK)
//   i_rst           synchronous reset, active high
//   s_in            word handshake (i_data / i_valid / o_ready)
//   o_tx            lane k slice at [k*BITS_PER_CLK +: BITS_PER_CLK]
//   o_word_start    o_tx carries the first slice of a word
//   o_underflow     sticky starvation flag
//   i_clr_underflow clears o_underflow (a simultaneous set wins)
module tmds_serializer_multi #(
  parameter int unsigned       WORD_W       = 10,
  parameter int unsigned       NCH          = 3,
  parameter int unsigned       BITS_PER_CLK = 2,
  parameter logic [WORD_W-1:0] IDLE_WORD    = 10'b1101010100
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  tmds_serializer_multi_if.slave       s_in,
  output logic [NCH*BITS_PER_CLK-1:0]  o_tx,
  output logic                         o_word_start,
  output logic                         o_underflow,
  input  logic                         i_clr_underflow
);

  localparam int unsigned PHASES = WORD_W / BITS_PER_CLK;
  localparam int unsigned PH_W   = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(PHASES - 1);

  generate
    if ((WORD_W % BITS_PER_CLK) != 0) begin : g_bad_cfg
      $error("tmds_serializer_multi: BITS_PER_CLK must divide WORD_W");
    end
  endgenerate

  logic [PH_W-1:0]       phase;
  logic [WORD_W-1:0]     sh [NCH];
  logic [NCH*WORD_W-1:0] hold;
  logic                  hold_full;
  logic                  started;

  logic boundary;
  logic accept;
  logic starve;

  assign boundary     = (phase == LAST_PHASE);
  assign s_in.o_ready = !hold_full || boundary;
  assign accept       = s_in.i_valid && s_in.o_ready;
  assign starve       = boundary && !hold_full && !accept && started;
  assign o_word_start = (phase == '0);

  always_comb begin
    o_tx = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      o_tx[k*BITS_PER_CLK +: BITS_PER_CLK] = sh[k][BITS_PER_CLK-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      phase       <= '0;
      hold_full   <= 1'b0;
      started     <= 1'b0;
      o_underflow <= 1'b0;
      for (int unsigned k = 0; k < NCH; k++) begin
        sh[k] <= IDLE_WORD;
      end
    end else begin
      phase <= boundary ? '0 : phase + PH_W'(1);

      // Writing hold on a bypass accept is harmless: hold_full stays 0.
      if (accept) begin
        hold    <= s_in.i_data;
        started <= 1'b1;
      end

      // At a boundary the buffer drains into sh; it stays occupied only when
      // it was full and a new word replaces it in the same cycle.
      hold_full <= boundary ? (hold_full && accept) : (hold_full || accept);

      for (int unsigned k = 0; k < NCH; k++) begin
        if (!boundary)
          sh[k] <= sh[k] >> BITS_PER_CLK;
        else if (hold_full)
          sh[k] <= hold[k*WORD_W +: WORD_W];
        else if (accept)
          sh[k] <= s_in.i_data[k*WORD_W +: WORD_W];
        else
          sh[k] <= IDLE_WORD;
      end

      if (starve)
        o_underflow <= 1'b1;
      else if (i_clr_underflow)
        o_underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tmds_serializer_multi.sv
// Randomised and directed checks of tmds_serializer_multi against a
// word-level reference model (queue of pending words, slot position).
module tb_tmds_serializer_multi;

  localparam int unsigned W  = 10;
  localparam int unsigned N  = 3;
  localparam int unsigned B  = 2;
  localparam int unsigned PH = W / B;
  localparam logic [W-1:0] IDLE = 10'b1101010100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT (3 lanes, 2 bits/clk)
  logic           rst = 1'b1;
  logic           clr = 1'b0;
  logic [N*B-1:0] tx;
  logic           ws;
  logic           uf;
  tmds_serializer_multi_if #(.WORD_W(W), .NCH(N)) io ();

  tmds_serializer_multi #(.WORD_W(W), .NCH(N), .BITS_PER_CLK(B), .IDLE_WORD(IDLE)) dut (
    .i_clk(clk), .i_rst(rst), .s_in(io.slave), .o_tx(tx),
    .o_word_start(ws), .o_underflow(uf), .i_clr_underflow(clr)
  );

  // single-lane, 1 bit/clk DUT
  logic rst2 = 1'b1;
  logic tx2;
  logic ws2;
  logic uf2;
  tmds_serializer_multi_if #(.WORD_W(W), .NCH(1)) io2 ();

  tmds_serializer_multi #(.WORD_W(W), .NCH(1), .BITS_PER_CLK(1), .IDLE_WORD(IDLE)) dut2 (
    .i_clk(clk), .i_rst(rst2), .s_in(io2.slave), .o_tx(tx2),
    .o_word_start(ws2), .o_underflow(uf2), .i_clr_underflow(1'b0)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [N*W-1:0] m_q[$];     // words accepted but not yet on the wire
  logic [N*W-1:0] m_cur;      // word currently being sent
  int             m_slot;     // slice index within m_cur
  bit             m_started;
  bit             m_uf;
  bit             m_known = 0;

  function automatic logic [N*W-1:0] idle_all();
    return {N{IDLE}};
  endfunction

  function automatic bit m_ready();
    return (m_q.size() == 0) || (m_slot == PH - 1);
  endfunction

  function automatic logic [N*B-1:0] m_tx();
    logic [N*B-1:0] r;
    logic [W-1:0]   w;
    r = '0;
    for (int k = 0; k < N; k++) begin
      w = m_cur[k*W +: W] / (W'(1) << (m_slot * B));
      r[k*B +: B] = w[B-1:0];
    end
    return r;
  endfunction

  task automatic m_step(input logic r, input logic v, input logic [N*W-1:0] d, input logic c);
    bit acc;
    bit set_uf;
    if (r) begin
      m_q.delete();
      m_cur = idle_all();
      m_slot = 0;
      m_started = 0;
      m_uf = 0;
      m_known = 1;
      return;
    end
    acc = v && m_ready();
    set_uf = 0;
    if (m_slot == PH - 1) begin
      if (m_q.size() != 0) begin
        m_cur = m_q.pop_front();
        if (acc) m_q.push_back(d);
      end else if (acc) begin
        m_cur = d;
      end else begin
        m_cur = idle_all();
        set_uf = m_started;
      end
      m_slot = 0;
    end else begin
      if (acc) m_q.push_back(d);
      m_slot++;
    end
    if (acc) m_started = 1;
    if (set_uf) m_uf = 1;
    else if (c) m_uf = 0;
  endtask

  // Drive one cycle: apply inputs, compare outputs to model, advance.
  task automatic tick(input logic r, input logic v, input logic [N*W-1:0] d, input logic c);
    rst = r;
    io.i_valid = v;
    io.i_data = d;
    clr = c;
    if (m_known) begin
      chk("tx", tx, m_tx());
      chk("word_start", ws, (m_slot == 0));
      chk("ready", io.o_ready, m_ready());
      chk("underflow", uf, m_uf);
    end
    m_step(r, v, d, c);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_to(input int p);
    for (int i = 0; i < PH && m_slot != p; i++) tick(1'b0, 1'b0, '0, 1'b0);
  endtask

  logic [N*W-1:0] rnd;
  int             acc_cnt;
  int             cnt;

  initial begin
    io.i_valid = 1'b0;
    io.i_data = '0;
    io2.i_valid = 1'b0;
    io2.i_data = '0;
    #1;

    // 1: reset then idle
    repeat (3) tick(1'b1, 1'b0, '0, 1'b0);
    chk("rst_tx", tx, {N{2'b00}});
    chk("rst_ws", ws, 1'b1);
    chk("rst_ready", io.o_ready, 1'b1);
    chk("rst_uf", uf, 1'b0);
    repeat (10) tick(1'b0, 1'b0, '0, 1'b0);

    // 2: single word accepted mid-slot
    idle_to(2);
    tick(1'b0, 1'b1, {10'h2AA, 10'h000, 10'h3FF}, 1'b0);
    chk("t2_ready_p3", io.o_ready, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b0);
    chk("t2_ready_p4", io.o_ready, 1'b1);
    tick(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < PH; i++) begin
      chk("t2_tx", tx, 6'b10_00_11);
      tick(1'b0, 1'b0, '0, 1'b0);
    end

    // 4: starvation, set-wins-over-clear, then clear
    chk("t4_uf_set", uf, 1'b1);
    repeat (3) tick(1'b0, 1'b0, '0, 1'b0);
    idle_to(PH - 1);
    tick(1'b0, 1'b0, '0, 1'b1);
    chk("t4_setclr", uf, 1'b1);
    tick(1'b0, 1'b0, '0, 1'b1);
    chk("t4_clr", uf, 1'b0);

    // 3: streaming with i_valid held high
    acc_cnt = 0;
    cnt = 0;
    for (int i = 0; i < 200 && acc_cnt < 20; i++) begin
      if (m_ready()) acc_cnt++;
      tick(1'b0, 1'b1, {W'(cnt + 2), W'(cnt + 1), W'(cnt)}, 1'b0);
      if (acc_cnt > cnt) cnt++;
    end
    chk("t3_accepted", acc_cnt, 20);

    // 5: reset at phase 3 with the buffer occupied
    idle_to(3);
    tick(1'b0, 1'b1, {N{10'h155}}, 1'b0);
    tick(1'b1, 1'b1, {N{10'h0F0}}, 1'b0);
    chk("t5_ws", ws, 1'b1);
    chk("t5_tx", tx, {N{2'b00}});
    chk("t5_ready", io.o_ready, 1'b1);
    repeat (2 * PH) tick(1'b0, 1'b0, '0, 1'b0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      rnd = {W'($urandom), W'($urandom), W'($urandom)};
      tick(($urandom_range(0, 199) == 0),
           (i < 750) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0),
           rnd,
           ($urandom_range(0, 15) == 0));
    end

    // 6: one lane, one bit per clock
    rst2 = 1'b1;
    @(posedge clk);
    #1;
    rst2 = 1'b0;
    chk("b1_rst_ws", ws2, 1'b1);
    chk("b1_rst_tx", tx2, 1'b0);
    chk("b1_rst_ready", io2.o_ready, 1'b1);
    repeat (W - 1) begin
      @(posedge clk);
      #1;
    end
    chk("b1_p9_ws", ws2, 1'b0);
    chk("b1_p9_ready", io2.o_ready, 1'b1);
    io2.i_valid = 1'b1;
    io2.i_data = 10'h001;
    @(posedge clk);
    #1;
    io2.i_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk("b1_tx", tx2, (i == 0));
      chk("b1_ws", ws2, (i == 0));
      @(posedge clk);
      #1;
    end
    chk("b1_idle_ws", ws2, 1'b1);
    chk("b1_idle_tx", tx2, 1'b0);
    chk("b1_uf", uf2, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
